// File: rtl/pb3_roll.sv
// pb3_roll: multi-cycle rotate/shift engine feeding the L register one bit per clock.
// {L, dout} acts as a 17-bit register for rotates; L captures roll16 whenever isroll is high.
module pb3_roll (
    input  logic        clk1,
    input  logic        nreset,
    input  logic        nstart,
    input  logic [1:0]  op,
    input  logic [3:0]  count,
    input  logic [15:0] din,
    input  logic        fl,
    output logic [15:0] dout,
    output logic        isroll,
    output logic        roll16,
    output logic        busy,
    output logic        ndone
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nx;
    logic [1:0]  op_q;
    logic [4:0]  rem, rem_nx;
    logic [15:0] dout_nx, stepped;
    logic        out_bit, load;

    // One step of the latched operation; left ops emit bit 15, right ops emit bit 0.
    always_comb begin
        stepped = dout;
        case (op_q)
            2'b00:   stepped = {dout[14:0], fl};
            2'b01:   stepped = {fl, dout[15:1]};
            2'b10:   stepped = {dout[14:0], 1'b0};
            default: stepped = {dout[15], dout[15:1]};
        endcase
        out_bit = op_q[0] ? dout[0] : dout[15];
    end

    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        dout_nx  = dout;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (!nstart) begin
                    state_nx = RUN;
                    rem_nx   = (count == 4'd0) ? 5'd16 : {1'b0, count};
                    dout_nx  = din;
                    load     = 1'b1;
                end
            end
            RUN: begin
                dout_nx = stepped;
                rem_nx  = (rem != 5'd0) ? rem - 5'd1 : 5'd0;
                if (rem <= 5'd1)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // isroll is registered alongside state so it tracks RUN without decode glitches.
    always_ff @(posedge clk1 or negedge nreset) begin
        if (!nreset) begin
            state  <= IDLE;
            rem    <= 5'd0;
            dout   <= 16'h0000;
            op_q   <= 2'b00;
            isroll <= 1'b0;
        end else begin
            state  <= state_nx;
            rem    <= rem_nx;
            dout   <= dout_nx;
            isroll <= (state_nx == RUN);
            if (load)
                op_q <= op;
        end
    end

    assign roll16 = isroll & out_bit;
    assign busy   = (state != IDLE);
    assign ndone  = (state != DONE);

endmodule

// File: tb/tb_pb3_roll.sv
// Bench for pb3_roll: random and directed ops with an L-register model, checked by a scoreboard.
// Expected results come from a 17-bit arithmetic rotate/shift model computed at accept time.
module tb_pb3_roll;

    logic        clk1 = 1'b0;
    logic        nreset = 1'b1;
    logic        nstart = 1'b1;
    logic [1:0]  op = 2'b00;
    logic [3:0]  count = 4'd0;
    logic [15:0] din = 16'h0000;
    logic [15:0] dout;
    logic        isroll, roll16, busy, ndone;

    logic l_reg = 1'b0;
    logic l_set_en = 1'b0;
    logic l_set_val = 1'b0;

    typedef struct {
        logic [15:0] d;
        logic        l;
        int          n;
        logic [15:0] seq;
    } exp_t;

    exp_t exp_q[$];
    int   acc_cyc_q[$];
    int   m_left = 0, cyc = 0, acc_cnt = 0, done_cnt = 0;
    int   total = 0, bad = 0;
    int   obs_n = 0;
    logic [15:0] obs_seq = 16'h0;

    pb3_roll dut (
        .clk1(clk1), .nreset(nreset), .nstart(nstart), .op(op), .count(count),
        .din(din), .fl(l_reg), .dout(dout), .isroll(isroll), .roll16(roll16),
        .busy(busy), .ndone(ndone)
    );

    always #5 clk1 = ~clk1;

    // External L register: loads roll16 while isroll is high; the bench can preset it.
    always @(posedge clk1) begin
        if (l_set_en)    l_reg <= l_set_val;
        else if (isroll) l_reg <= roll16;
    end

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [3:0] c,
                                   input logic [15:0] d, input logic l);
        exp_t e;
        int n, rl;
        logic [16:0] v;
        logic [33:0] vv;
        logic [32:0] x;
        logic signed [31:0] y;
        n = (c == 4'd0) ? 16 : int'(c);
        e.n = n;
        e.seq = 16'h0;
        for (int k = 1; k <= n; k++)
            e.seq = {e.seq[14:0], (o[0] ? d[k-1] : d[16-k])};
        v = {l, d};
        e.d = 16'h0;
        e.l = 1'b0;
        case (o)
            2'b00, 2'b01: begin
                rl = o[0] ? 17 - n : n;
                vv = {v, v} << rl;
                e.d = vv[32:17];
                e.l = vv[33];
            end
            2'b10: begin
                x = {17'b0, d} << n;
                e.d = x[15:0];
                e.l = x[16];
            end
            default: begin
                y = $signed({d, 16'h0000}) >>> n;
                e.d = y[31:16];
                e.l = y[15];
            end
        endcase
        return e;
    endfunction

    // Acceptance model: idle unless an op is outstanding; an op occupies N+1 edges after accept.
    initial forever begin
        @(posedge clk1 or negedge nreset);
        if (!nreset) begin
            if (m_left > 0 && exp_q.size() > 0)
                exp_q.delete(exp_q.size() - 1);
            m_left = 0;
        end else begin
            cyc++;
            if (m_left > 0) begin
                m_left--;
            end else if (!nstart) begin
                exp_q.push_back(model(op, count, din, l_reg));
                acc_cyc_q.push_back(cyc);
                acc_cnt++;
                m_left = ((count == 4'd0) ? 16 : int'(count)) + 1;
            end
        end
    end

    // Monitor: collects roll16 during isroll and checks each completion against the queue.
    initial forever begin
        exp_t e;
        @(negedge clk1);
        if (!nreset) begin
            obs_n = 0;
            obs_seq = 16'h0;
        end else begin
            chk("busy", int'(busy), int'(m_left > 0));
            if (isroll) begin
                obs_seq = {obs_seq[14:0], roll16};
                obs_n++;
            end else begin
                chk("roll16_outside_run", int'(roll16), 0);
            end
            if (!ndone) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("dout", int'(dout), int'(e.d));
                    chk("l_final", int'(l_reg), int'(e.l));
                    chk("isroll_cycles", obs_n, e.n);
                    chk("roll16_seq", int'(obs_seq), int'(e.seq));
                end
                obs_n = 0;
                obs_seq = 16'h0;
            end
        end
    end

    task automatic set_l(input logic v);
        @(negedge clk1);
        l_set_en = 1'b1;
        l_set_val = v;
        @(negedge clk1);
        l_set_en = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (m_left == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk1);
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    // Pulse nstart for one edge, then scramble operands to show they are latched.
    task automatic start(input logic [1:0] o, input logic [3:0] c, input logic [15:0] d);
        op = o;
        count = c;
        din = d;
        nstart = 1'b0;
        @(negedge clk1);
        nstart = 1'b1;
        op = 2'($urandom);
        count = 4'($urandom);
        din = 16'($urandom);
    endtask

    task automatic run(input logic [1:0] o, input logic [3:0] c, input logic [15:0] d,
                       input logic l);
        wait_idle();
        set_l(l);
        start(o, c, d);
        wait_idle();
        @(negedge clk1);
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_dout"}, int'(dout), 0);
        chk({nm, "_isroll"}, int'(isroll), 0);
        chk({nm, "_roll16"}, int'(roll16), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_ndone"}, int'(ndone), 1);
    endtask

    initial begin
        int a, dc;
        #2 nreset = 1'b0;
        repeat (3) @(negedge clk1);
        chk_reset_outs("rst_hold");
        nreset = 1'b1;
        @(negedge clk1);
        chk_reset_outs("rst_release");

        run(2'b00, 4'd1, 16'h8000, 1'b0);
        chk("t1_dout", int'(dout), 16'h0000);
        chk("t1_l", int'(l_reg), 1);
        run(2'b00, 4'd0, 16'h1234, 1'b0);
        chk("t2_dout", int'(dout), 16'h091A);
        chk("t2_l", int'(l_reg), 0);
        run(2'b10, 4'd3, 16'hA001, 1'b0);
        chk("t3_dout", int'(dout), 16'h0008);
        chk("t3_l", int'(l_reg), 1);
        run(2'b11, 4'd4, 16'h8010, 1'b1);
        chk("t4_dout", int'(dout), 16'hF801);
        chk("t4_l", int'(l_reg), 0);
        run(2'b01, 4'd1, 16'h0001, 1'b1);
        chk("t5_dout", int'(dout), 16'h8000);
        chk("t5_l", int'(l_reg), 1);

        // nstart pulsed mid-RUN must be ignored.
        wait_idle();
        set_l(1'b0);
        a = acc_cnt;
        start(2'b01, 4'd8, 16'hBEEF);
        repeat (3) @(negedge clk1);
        nstart = 1'b0;
        @(negedge clk1);
        nstart = 1'b1;
        wait_idle();
        chk("ignored_start_accepts", acc_cnt - a, 1);

        // nstart held low: second op accepted N+2 edges after the first.
        wait_idle();
        set_l(1'b1);
        a = acc_cnt;
        op = 2'b00; count = 4'd2; din = 16'hC003; nstart = 1'b0;
        @(negedge clk1);
        op = 2'b11; count = 4'd5; din = 16'h9A5A;
        for (int i = 0; i < 20 && acc_cnt < a + 2; i++) @(negedge clk1);
        nstart = 1'b1;
        chk("b2b_accepts", acc_cnt - a, 2);
        if (acc_cyc_q.size() >= 2)
            chk("b2b_gap", acc_cyc_q[acc_cyc_q.size()-1] - acc_cyc_q[acc_cyc_q.size()-2], 4);
        wait_idle();

        // Reset during step 3 of a 10-step op.
        wait_idle();
        set_l(1'b0);
        dc = done_cnt;
        start(2'b00, 4'd10, 16'h1234);
        repeat (2) @(negedge clk1);
        nreset = 1'b0;
        #1;
        chk_reset_outs("rst_mid");
        repeat (2) @(negedge clk1);
        nreset = 1'b1;
        repeat (15) @(negedge clk1);
        chk("rst_no_done", done_cnt, dc);

        for (int it = 0; it < 40; it++) begin
            wait_idle();
            set_l(1'($urandom));
            start(2'($urandom), 4'($urandom), 16'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 3)) @(negedge clk1);
                nstart = 1'b0;
                @(negedge clk1);
                nstart = 1'b1;
            end
        end
        wait_idle();
        repeat (3) @(negedge clk1);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
